// File: rtl/game1_timer.sv
// Reaction-game timing datapath: LFSR-randomised start delay, plus a millisecond reaction counter in binary and BCD.
// All outputs are registered. delay_done rises delay_ms*TICK_DIV+1 cycles after the new_number rise.
module game1_timer #(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned RAND_BITS    = 11,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_number,
   input  logic        rflag,
   output logic        delay_done,
   output logic [13:0] reaction_ms,
   output logic [15:0] reaction_bcd,
   output logic        result_valid,
   output logic        overflow
);

   localparam int unsigned TICK_DIV  = CLK_HZ / 1000;
   localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW        = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [13:0]   MS_MAX    = 14'd9999;

   logic [15:0]   lfsr_q, lfsr_d;
   logic          nn_q, rf_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [DW-1:0] delay_cnt_q, delay_cnt_d;
   logic          armed_q, armed_d;
   logic          delay_done_q, delay_done_d;
   logic [13:0]   ms_q, ms_d;
   logic [15:0]   bcd_q, bcd_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;

   logic nn_rise, rf_rise, rf_fall, tick;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign nn_rise = new_number & ~nn_q;
   assign rf_rise = rflag & ~rf_q;
   assign rf_fall = ~rflag & rf_q;
   assign tick    = (presc_q == PRESC_MAX) & ~nn_rise & ~rf_rise;

   always_comb begin
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      presc_d = (nn_rise | rf_rise | tick) ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      delay_cnt_d  = delay_cnt_q;
      armed_d      = armed_q;
      delay_done_d = delay_done_q;
      if (nn_rise) begin
         delay_cnt_d  = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
         armed_d      = 1'b1;
         delay_done_d = 1'b0;
      end else if (new_number) begin
         if (tick && (delay_cnt_q != '0)) begin
            delay_cnt_d = delay_cnt_q - DW'(1);
         end
         delay_done_d = armed_q && (delay_cnt_q == '0);
      end else begin
         armed_d      = 1'b0;
         delay_done_d = 1'b0;
      end
   end

   // The count window is rflag delayed by one cycle, matching the prescaler
   // restart on the rise, so a pulse of N*TICK_DIV cycles reads exactly N ms.
   always_comb begin
      ms_d    = ms_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      if (rf_rise) begin
         ms_d  = '0;
         bcd_d = '0;
         ovf_d = 1'b0;
      end else if (rf_q && tick) begin
         if (ms_q == MS_MAX) begin
            ovf_d = 1'b1;
         end else begin
            ms_d  = ms_q + 14'd1;
            bcd_d = bcd_inc(bcd_q);
            if (ms_q == (MS_MAX - 14'd1)) begin
               ovf_d = 1'b1;
            end
         end
      end
      if (rf_fall) begin
         valid_d = 1'b1;
      end else if (rf_rise || nn_rise) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q       <= LFSR_SEED;
         nn_q         <= 1'b0;
         rf_q         <= 1'b0;
         presc_q      <= '0;
         delay_cnt_q  <= '0;
         armed_q      <= 1'b0;
         delay_done_q <= 1'b0;
         ms_q         <= '0;
         bcd_q        <= '0;
         valid_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         nn_q         <= new_number;
         rf_q         <= rflag;
         presc_q      <= presc_d;
         delay_cnt_q  <= delay_cnt_d;
         armed_q      <= armed_d;
         delay_done_q <= delay_done_d;
         ms_q         <= ms_d;
         bcd_q        <= bcd_d;
         valid_q      <= valid_d;
         ovf_q        <= ovf_d;
      end
   end

   assign delay_done   = delay_done_q;
   assign reaction_ms  = ms_q;
   assign reaction_bcd = bcd_q;
   assign result_valid = valid_q;
   assign overflow     = ovf_q;

endmodule
